// File: rtl/sys1_snd_pkg.sv
// Shared definitions for the System 1 sound command path.
// Holds the command-queue FSM encoding and default sizing.
package sys1_snd_pkg;

    localparam int unsigned SNDCMD_DEPTH = 4;
    localparam int unsigned SNDCMD_PULSE = 4;
    localparam int unsigned SNDCMD_GAP   = 8192;

    // FSM encoding kept as plain constants for older blocks that compare raw codes
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPulse = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sys1_sndcmd_fifo.sv
// DEPTH x 8 register FIFO with registered count/full/empty and synchronous flush.
// Pushes while full and pops while empty are ignored.
module sys1_sndcmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk8M,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push_i & ~full_q & ~flush_i;
    assign do_pop  = pop_i & ~empty_q & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk8M or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge clk8M) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/sys1_sndcmd_queue.sv
// Main-CPU sound command queue: buffers command writes and replays them as
// stretched, spaced sndstart pulses so the sound CPU never misses one.
module sys1_sndcmd_queue
    import sys1_snd_pkg::*;
#(
    parameter int unsigned DEPTH     = SNDCMD_DEPTH,
    parameter int unsigned PULSE_CYC = SNDCMD_PULSE,
    parameter int unsigned GAP_CYC   = SNDCMD_GAP
) (
    input  logic                   clk8M,
    input  logic                   reset,
    input  logic                   cmd_we,
    input  logic [7:0]             cmd_data,
    input  logic                   flush,
    input  logic                   ovf_clr,
    output logic [7:0]             sndno,
    output logic                   sndstart,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf
);

    localparam int unsigned TW = $clog2(max_u(PULSE_CYC, GAP_CYC));

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    sndno_q, sndno_d;
    logic          sndstart_q, sndstart_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    head_data;
    logic          pop;
    logic          drop;

    // Full is sampled pre-edge, so a same-edge pop never rescues a write into a full queue.
    assign drop = cmd_we & full & ~flush;
    assign pop  = (state_q == StIdle) & ~empty & ~flush;

    sys1_sndcmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk8M   (clk8M),
        .reset   (reset),
        .push_i  (cmd_we),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (cmd_data),
        .rdata_o (head_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sndno_d    = sndno_q;
        sndstart_d = sndstart_q;
        if (flush) begin
            state_d    = StIdle;
            timer_d    = '0;
            sndstart_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        sndno_d    = head_data;
                        sndstart_d = 1'b1;
                        timer_d    = TW'(PULSE_CYC - 1);
                        state_d    = StPulse;
                    end
                end
                StPulse: begin
                    if (timer_q == '0) begin
                        sndstart_d = 1'b0;
                        timer_d    = TW'(GAP_CYC - 1);
                        state_d    = StGap;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                StGap: begin
                    if (timer_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d    = StIdle;
                    timer_d    = '0;
                    sndstart_d = 1'b0;
                end
            endcase
        end
    end

    // A drop on the same edge as ovf_clr leaves the flag set.
    assign ovf_d = drop | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk8M or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            sndno_q    <= 8'h00;
            sndstart_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sndno_q    <= sndno_d;
            sndstart_q <= sndstart_d;
            ovf_q      <= ovf_d;
        end
    end

    assign sndno    = sndno_q;
    assign sndstart = sndstart_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_sys1_sndcmd_queue.sv
// Directed bench for sys1_sndcmd_queue at default parameters (DEPTH=4, PULSE=4, GAP=8192).
module tb_sys1_sndcmd_queue;

    localparam int SPACING = 8197;

    logic       clk8M = 1'b0;
    logic       reset;
    logic       cmd_we;
    logic [7:0] cmd_data;
    logic       flush;
    logic       ovf_clr;
    logic [7:0] sndno;
    logic       sndstart;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    int         rise_at[$];
    int         fall_at[$];
    logic [7:0] rise_no[$];
    logic [7:0] wr_q[$];
    int         unstable;
    int         max_cnt;

    sys1_sndcmd_queue dut (
        .clk8M    (clk8M),
        .reset    (reset),
        .cmd_we   (cmd_we),
        .cmd_data (cmd_data),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .sndno    (sndno),
        .sndstart (sndstart),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf)
    );

    always #5 clk8M = ~clk8M;

    task automatic tick();
        @(posedge clk8M);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Runs n cycles, feeding wr_q one write per cycle, and records pulse edges.
    task automatic watch(input int n);
        logic       prev;
        logic [7:0] prev_no;
        rise_at.delete();
        fall_at.delete();
        rise_no.delete();
        unstable = 0;
        max_cnt  = 0;
        prev     = sndstart;
        prev_no  = sndno;
        for (int i = 0; i < n; i++) begin
            if (wr_q.size() > 0) begin
                cmd_we   = 1'b1;
                cmd_data = wr_q.pop_front();
            end else begin
                cmd_we = 1'b0;
            end
            tick();
            if (sndstart && !prev) begin
                rise_at.push_back(i + 1);
                rise_no.push_back(sndno);
            end
            if (!sndstart && prev) fall_at.push_back(i + 1);
            if (sndstart && prev && sndno !== prev_no) unstable++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            prev    = sndstart;
            prev_no = sndno;
        end
        cmd_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_we = 1'b0; cmd_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({sndno, sndstart, count, full, empty, ovf} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got sndno=%h st=%b cnt=%0d full=%b empty=%b ovf=%b, want 00 0 0 0 1 0",
                     sndno, sndstart, count, full, empty, ovf);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [7:0] d);
        cmd_we = 1'b1; cmd_data = d;
        tick();
        cmd_we = 1'b0;
        checks++;
        if (count !== 3'd1 || sndstart !== 1'b0) begin
            errors++;
            $display("FAIL single_after_write: got cnt=%0d st=%b, want 1 0", count, sndstart);
        end
        tick();
        checks++;
        if (sndstart !== 1'b1 || sndno !== d) begin
            errors++;
            $display("FAIL single_rise: got st=%b sndno=%h, want 1 %h", sndstart, sndno, d);
        end
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_count: got cnt=%0d empty=%b, want 0 1", count, empty);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (sndstart !== 1'b1) begin
                errors++;
                $display("FAIL single_pulse_held_%0d: got st=%b, want 1", k, sndstart);
            end
        end
        tick();
        checks++;
        if (sndstart !== 1'b0 || sndno !== d) begin
            errors++;
            $display("FAIL single_pulse_end: got st=%b sndno=%h, want 0 %h", sndstart, sndno, d);
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        for (int k = 1; k <= 3; k++) wr_q.push_back(8'(k));
        watch(2 * SPACING + 20);
        checks++;
        if (rise_at.size() !== 3 || fall_at.size() !== 3) begin
            errors++;
            $display("FAIL b2b_pulse_count: got rises=%0d falls=%0d, want 3 3", rise_at.size(), fall_at.size());
        end
        checks++;
        if (rise_at.size() > 0 && rise_at[0] !== 2) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d, want 2", rise_at[0]);
        end
        for (int k = 0; k < rise_at.size(); k++) begin
            checks++;
            if (rise_no[k] !== 8'(k + 1)) begin
                errors++;
                $display("FAIL b2b_order_%0d: got %h, want %h", k, rise_no[k], 8'(k + 1));
            end
            if (k > 0) begin
                checks++;
                if (rise_at[k] - rise_at[k-1] !== SPACING) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d, want %0d", k, rise_at[k] - rise_at[k-1], SPACING);
                end
            end
            if (k < fall_at.size()) begin
                checks++;
                if (fall_at[k] - rise_at[k] !== 4) begin
                    errors++;
                    $display("FAIL b2b_width_%0d: got %0d, want 4", k, fall_at[k] - rise_at[k]);
                end
            end
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL b2b_sndno_stable: got %0d changes, want 0", unstable);
        end
    endtask

    task automatic test_overflow();
        do_flush();
        for (int k = 0; k < 6; k++) wr_q.push_back(8'h21 + 8'(k));
        watch(5 * SPACING + 20);
        checks++;
        if (rise_at.size() !== 5) begin
            errors++;
            $display("FAIL ovf_pulse_count: got %0d, want 5", rise_at.size());
        end
        for (int k = 0; k < rise_at.size(); k++) begin
            checks++;
            if (rise_no[k] !== 8'h21 + 8'(k)) begin
                errors++;
                $display("FAIL ovf_order_%0d: got %h, want %h", k, rise_no[k], 8'h21 + 8'(k));
            end
            if (k > 0) begin
                checks++;
                if (rise_at[k] - rise_at[k-1] !== SPACING) begin
                    errors++;
                    $display("FAIL ovf_spacing_%0d: got %0d, want %0d", k, rise_at[k] - rise_at[k-1], SPACING);
                end
            end
        end
        checks++;
        if (max_cnt !== 4) begin
            errors++;
            $display("FAIL ovf_peak_count: got %0d, want 4", max_cnt);
        end
        checks++;
        if (ovf !== 1'b1 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b cnt=%0d empty=%b full=%b, want 1 0 1 0", ovf, count, empty, full);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b, want 0", ovf);
        end
    endtask

    task automatic test_flush_mid_pulse();
        do_flush();
        for (int k = 0; k < 3; k++) wr_q.push_back(8'h51 + 8'(k));
        watch(3);
        checks++;
        if (sndstart !== 1'b1 || count !== 3'd2) begin
            errors++;
            $display("FAIL flush_setup: got st=%b cnt=%0d, want 1 2", sndstart, count);
        end
        do_flush();
        checks++;
        if (sndstart !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || sndno !== 8'h51) begin
            errors++;
            $display("FAIL flush_effect: got st=%b cnt=%0d empty=%b sndno=%h, want 0 0 1 51",
                     sndstart, count, empty, sndno);
        end
        watch(40);
        checks++;
        if (rise_at.size() !== 0 || sndno !== 8'h51) begin
            errors++;
            $display("FAIL flush_no_pulse: got rises=%0d sndno=%h, want 0 51", rise_at.size(), sndno);
        end
    endtask

    task automatic test_we_flush_same_edge();
        cmd_we = 1'b1; cmd_data = 8'h77; flush = 1'b1;
        tick();
        cmd_we = 1'b0; flush = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || ovf !== 1'b0 || sndstart !== 1'b0) begin
            errors++;
            $display("FAIL we_flush_state: got cnt=%0d empty=%b ovf=%b st=%b, want 0 1 0 0",
                     count, empty, ovf, sndstart);
        end
        watch(20);
        checks++;
        if (rise_at.size() !== 0) begin
            errors++;
            $display("FAIL we_flush_no_pulse: got %0d rises, want 0", rise_at.size());
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) wr_q.push_back(8'h41 + 8'(k));
        watch(10);
        checks++;
        if (sndstart !== 1'b0 || count !== 3'd2 || sndno !== 8'h41) begin
            errors++;
            $display("FAIL areset_setup: got st=%b cnt=%0d sndno=%h, want 0 2 41", sndstart, count, sndno);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sndno, sndstart, count, full, empty, ovf} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: got sndno=%h st=%b cnt=%0d full=%b empty=%b ovf=%b, want 00 0 0 0 1 0",
                     sndno, sndstart, count, full, empty, ovf);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        test_single(8'h12);
    endtask

    initial begin
        test_reset();
        test_single(8'h12);
        test_back_to_back();
        test_overflow();
        test_flush_mid_pulse();
        test_we_flush_same_edge();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
